// File: rtl/cla_seq_arbiter_if.sv
// Request/response bundle for the two-requester sequential CLA adder.
// The arbiter sits on the slave side; the requesters and the result consumer
// sit on the master side.
interface cla_seq_arbiter_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;

    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;

    logic         rsp_valid;
    logic [W:0]   rsp_sum;
    logic         rsp_id;
    logic         rsp_ready;

    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_id,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_id,
        output busy
    );
endinterface

// File: rtl/cla_seq_arbiter.sv
// Two-requester round-robin arbiter in front of a nibble-serial adder.
// A single 4-bit carry-lookahead slice is reused once per nibble, so one add
// takes NIBBLES cycles in CALC followed by a held response in RESP.
module cla_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_seq_arbiter_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    sum_q, sum_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;

    logic          grant_id;
    logic          req0_rdy;
    logic          req1_rdy;
    logic          accept;

    logic [KW+1:0] nib_base;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [3:0]    slice_g;
    logic [3:0]    slice_p;
    logic [4:0]    slice_c;
    logic [3:0]    slice_sum;
    logic          slice_cout;

    // Round-robin grant: a lone requester wins, a contested grant goes to the one not served last.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        req0_rdy = !rst && (state_q == IDLE) && bus.req0_valid && !grant_id;
        req1_rdy = !rst && (state_q == IDLE) && bus.req1_valid &&  grant_id;
        accept   = req0_rdy || req1_rdy;
    end

    // The single shared 4-bit carry-lookahead slice, fed with nibble k of the latched operands.
    always_comb begin
        nib_base   = {k_q, 2'b00};
        slice_a    = a_q[nib_base +: 4];
        slice_b    = b_q[nib_base +: 4];
        slice_g    = slice_a & slice_b;
        slice_p    = slice_a ^ slice_b;
        slice_c    = '0;
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0] | (slice_p[0] & slice_c[0]);
        slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_sum  = slice_p ^ slice_c[3:0];
        slice_cout = slice_c[4];
    end

    // Next-state logic: accept in IDLE, one nibble per CALC cycle, hold the result in RESP.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        k_d         = k_q;
        carry_d     = carry_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? bus.req1_a : bus.req0_a;
                    b_d     = grant_id ? bus.req1_b : bus.req0_b;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    k_d     = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[nib_base +: 4] = slice_sum;
                carry_d = slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    sum_d[W]    = slice_cout;
                    k_d         = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register; operands need no reset since they are only read after an acceptance.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req0_ready = req0_rdy;
    assign bus.req1_ready = req1_rdy;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_id     = id_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cla_seq_arbiter.sv
// Self-checking bench for cla_seq_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level transaction model.
module tb_cla_seq_arbiter;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    bit   mdl_last;

    cla_seq_arbiter_if #(.NIBBLES(NIBBLES)) bus ();

    cla_seq_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Run one uncontested request through to its handshake; reports observed values only.
    task automatic single_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W:0] sum, output logic id, output int lat,
                             output logic rdy_ok, output logic rdy_after);
        bus.rsp_ready = 1'b1;
        if (who) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        rdy_ok = who ? (bus.req1_ready && !bus.req0_ready) : (bus.req0_ready && !bus.req1_ready);
        step();
        rdy_after = bus.req0_ready | bus.req1_ready;
        mdl_last = who;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        sum = bus.rsp_sum;
        id  = bus.rsp_id;
        step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        step();
        step();
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%b want=0", bus.req0_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_sum !== '0) $display("FAIL reset_rsp_sum got=%h want=0", bus.rsp_sum); else n_pass++;
        n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id got=%b want=0", bus.rsp_id); else n_pass++;
        rst = 1'b0;
        mdl_last = 1'b1;
        bus.req0_valid = 1'b0;
        #1;
        n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL reset_ready_idle got=%b want=00", {bus.req0_ready, bus.req1_ready}); else n_pass++;
        // A valid that appears and vanishes before a clock edge is never accepted.
        bus.req0_valid = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) $display("FAIL cancel_ready_up got=%b want=1", bus.req0_ready); else n_pass++;
        bus.req0_valid = 1'b0;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0) $display("FAIL cancel_ready_down got=%b want=0", bus.req0_ready); else n_pass++;
        step();
        step();
        n_checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) $display("FAIL cancel_no_op got busy,rsp_valid=%b want=00", {bus.busy, bus.rsp_valid}); else n_pass++;
    endtask

    task automatic test_single();
        logic [W:0] sum; logic id; int lat; logic rok; logic raft;
        single_op(1'b0, 16'h0002, 16'h0007, sum, id, lat, rok, raft);
        n_checks++; if (rok !== 1'b1) $display("FAIL single_ready got=%b want=1", rok); else n_pass++;
        n_checks++; if (raft !== 1'b0) $display("FAIL single_ready_one_cycle got=%b want=0", raft); else n_pass++;
        n_checks++; if (lat != NIBBLES + 1) $display("FAIL single_latency got=%0d want=%0d", lat, NIBBLES + 1); else n_pass++;
        n_checks++; if (sum !== 17'h00009) $display("FAIL single_sum got=%h want=00009", sum); else n_pass++;
        n_checks++; if (id !== 1'b0) $display("FAIL single_id got=%b want=0", id); else n_pass++;
        n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL single_done got=%b want=00", {bus.rsp_valid, bus.busy}); else n_pass++;
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] ta [0:4];
        logic [W-1:0] tb [0:4];
        logic [W:0]   want [0:4];
        logic [W:0]   sum; logic id; int lat; logic rok; logic raft;
        bit who;
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; want[0] = 17'h10000;
        ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; want[1] = 17'h1FFFE;
        ta[2] = 16'h000D; tb[2] = 16'h000A; want[2] = 17'h00017;
        ta[3] = 16'h0FFF; tb[3] = 16'hF001; want[3] = 17'h10000;
        ta[4] = 16'h8000; tb[4] = 16'h8000; want[4] = 17'h10000;
        for (int i = 0; i < 5; i++) begin
            who = i[0];
            single_op(who, ta[i], tb[i], sum, id, lat, rok, raft);
            n_checks++; if (sum !== want[i]) $display("FAIL carry_sum[%0d] got=%h want=%h", i, sum, want[i]); else n_pass++;
            n_checks++; if (id !== who) $display("FAIL carry_id[%0d] got=%b want=%b", i, id, who); else n_pass++;
        end
    endtask

    task automatic test_contention();
        logic [W:0] q_sum[$];
        logic       q_id[$];
        bit         want_g;
        bit         acc;
        int         cyc;
        int         n_acc;
        int         n_rsp;
        int         last_acc;
        apply_reset();
        cyc = 0; n_acc = 0; n_rsp = 0; last_acc = 0;
        bus.rsp_ready  = 1'b1;
        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        while (n_rsp < 4 && cyc < 80) begin
            #1;
            acc = bus.req0_ready || bus.req1_ready;
            if (acc) begin
                want_g = ~mdl_last;
                n_checks++;
                if ({bus.req1_ready, bus.req0_ready} !== (want_g ? 2'b10 : 2'b01))
                    $display("FAIL contend_grant[%0d] got r1r0=%b want grant=%0d", n_acc, {bus.req1_ready, bus.req0_ready}, want_g);
                else n_pass++;
                q_sum.push_back(want_g ? ref_sum(bus.req1_a, bus.req1_b) : ref_sum(bus.req0_a, bus.req0_b));
                q_id.push_back(want_g);
                mdl_last = want_g;
                if (n_acc > 0) begin
                    n_checks++;
                    if (cyc - last_acc != NIBBLES + 2) $display("FAIL contend_spacing got=%0d want=%0d", cyc - last_acc, NIBBLES + 2);
                    else n_pass++;
                end
                last_acc = cyc;
                n_acc++;
            end
            step();
            cyc++;
            if (acc) begin
                if (want_g) begin bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); end
                else begin bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); end
                if (n_acc == 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
            end
            if (bus.rsp_valid) begin
                if (q_sum.size() == 0) begin
                    n_checks++; $display("FAIL contend_unexpected_rsp got sum=%h want none", bus.rsp_sum);
                end else begin
                    n_checks++; if (bus.rsp_sum !== q_sum[0]) $display("FAIL contend_sum[%0d] got=%h want=%h", n_rsp, bus.rsp_sum, q_sum[0]); else n_pass++;
                    n_checks++; if (bus.rsp_id !== q_id[0]) $display("FAIL contend_id[%0d] got=%b want=%b", n_rsp, bus.rsp_id, q_id[0]); else n_pass++;
                    void'(q_sum.pop_front());
                    void'(q_id.pop_front());
                end
                n_rsp++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_checks++; if (n_rsp != 4) $display("FAIL contend_timeout got=%0d responses want=4", n_rsp); else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        logic [W:0]   want;
        int           lat;
        a = W'($urandom); b = W'($urandom);
        want = ref_sum(a, b);
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        #1;
        n_checks++; if (bus.req1_ready !== 1'b1) $display("FAIL bp_accept got=%b want=1", bus.req1_ready); else n_pass++;
        step();
        mdl_last = 1'b1;
        bus.req1_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin step(); lat++; end
        n_checks++; if (lat != NIBBLES + 1) $display("FAIL bp_latency got=%0d want=%0d", lat, NIBBLES + 1); else n_pass++;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL bp_ready[%0d] got=%b want=00", i, {bus.req0_ready, bus.req1_ready}); else n_pass++;
            n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid_held[%0d] got=%b want=1", i, bus.rsp_valid); else n_pass++;
            n_checks++; if (bus.rsp_sum !== want) $display("FAIL bp_sum[%0d] got=%h want=%h", i, bus.rsp_sum, want); else n_pass++;
            n_checks++; if (bus.rsp_id !== 1'b1) $display("FAIL bp_id[%0d] got=%b want=1", i, bus.rsp_id); else n_pass++;
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_before_release got=%b want=1", bus.rsp_valid); else n_pass++;
        step();
        n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL bp_release got=%b want=00", {bus.rsp_valid, bus.busy}); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [W:0] sum; logic id; int lat; logic rok; logic raft;
        bit seen;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h4321;
        step();
        bus.req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_last = 1'b1;
        n_checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) $display("FAIL midrst_state got=%b want=00", {bus.busy, bus.rsp_valid}); else n_pass++;
        n_checks++; if (bus.rsp_sum !== '0) $display("FAIL midrst_sum got=%h want=0", bus.rsp_sum); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_rsp got=%b want=0", seen); else n_pass++;
        single_op(1'b1, 16'h0005, 16'h0003, sum, id, lat, rok, raft);
        n_checks++; if (sum !== 17'h00008) $display("FAIL midrst_next_sum got=%h want=00008", sum); else n_pass++;
        n_checks++; if (id !== 1'b1) $display("FAIL midrst_next_id got=%b want=1", id); else n_pass++;
        n_checks++; if (lat != NIBBLES + 1) $display("FAIL midrst_next_latency got=%0d want=%0d", lat, NIBBLES + 1); else n_pass++;
    endtask

    // Random valids, operands and consumer stalls against a transaction-level model.
    task automatic test_random();
        logic [W:0] q_sum[$];
        logic       q_id[$];
        bit m_busy, m_resp, m_grant, e_r0, e_r1, hs;
        int m_cnt, ops, cyc;
        m_busy = 0; m_resp = 0; m_cnt = 0; ops = 0; cyc = 0;
        while (ops < 30 && cyc < 3000) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
            bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r0 = 0; e_r1 = 0; m_grant = 0;
            if (!m_busy) begin
                if (bus.req0_valid && bus.req1_valid) m_grant = ~mdl_last;
                else m_grant = bus.req1_valid;
                e_r0 = bus.req0_valid && !m_grant;
                e_r1 = bus.req1_valid && m_grant;
            end
            n_checks++; if (bus.req0_ready !== e_r0) $display("FAIL rand_ready0 cyc=%0d got=%b want=%b", cyc, bus.req0_ready, e_r0); else n_pass++;
            n_checks++; if (bus.req1_ready !== e_r1) $display("FAIL rand_ready1 cyc=%0d got=%b want=%b", cyc, bus.req1_ready, e_r1); else n_pass++;
            hs = m_resp && bus.rsp_ready;
            if (e_r0 || e_r1) begin
                q_sum.push_back(m_grant ? ref_sum(bus.req1_a, bus.req1_b) : ref_sum(bus.req0_a, bus.req0_b));
                q_id.push_back(m_grant);
                mdl_last = m_grant;
            end
            step();
            cyc++;
            if (hs) begin
                m_busy = 0; m_resp = 0;
                void'(q_sum.pop_front());
                void'(q_id.pop_front());
                ops++;
            end else if (e_r0 || e_r1) begin
                m_busy = 1; m_cnt = 0;
            end else if (m_busy && !m_resp) begin
                m_cnt++;
                if (m_cnt == NIBBLES) m_resp = 1;
            end
            n_checks++; if (bus.rsp_valid !== m_resp) $display("FAIL rand_rsp_valid cyc=%0d got=%b want=%b", cyc, bus.rsp_valid, m_resp); else n_pass++;
            n_checks++; if (bus.busy !== m_busy) $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, bus.busy, m_busy); else n_pass++;
            if (m_resp && q_sum.size() > 0) begin
                n_checks++; if (bus.rsp_sum !== q_sum[0]) $display("FAIL rand_sum cyc=%0d got=%h want=%h", cyc, bus.rsp_sum, q_sum[0]); else n_pass++;
                n_checks++; if (bus.rsp_id !== q_id[0]) $display("FAIL rand_id cyc=%0d got=%b want=%b", cyc, bus.rsp_id, q_id[0]); else n_pass++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        n_checks++; if (ops != 30) $display("FAIL rand_timeout got=%0d ops want=30", ops); else n_pass++;
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mdl_last = 1'b1;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        test_reset();
        test_single();
        test_carry_chain();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_seq_arbiter.md
CLA_SEQ_ARBITER -- requirements
Module: cla_seq_arbiter

Interface
REQ-001 Parameter NIBBLES, default 4: operand width is 4*NIBBLES bits (W = 16 at default); all widths below use W.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an add request.
REQ-005 req0_a, req0_b  input  W each  requester 0 operands.
REQ-006 req0_ready  output  1  request 0 accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_sum  output  W+1  unsigned sum a+b; MSB is the final carry-out.
REQ-010 rsp_id  output  1  requester that owns rsp_sum (0 or 1).
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Block SHALL contain exactly one 4-bit carry-lookahead slice, reused for every nibble of every add.
- Slice: generate/propagate form, carry-in, 4-bit sum, carry-out.
REQ-014 FSM states SHALL be IDLE, CALC and RESP.
REQ-015 IDLE: reqN_ready SHALL be high combinationally only for the granted requester, and only while that requester's valid is high.
- Ready SHALL be low in every other state.
REQ-016 Acceptance SHALL occur on reqN_valid && reqN_ready.
- On acceptance: latch a, b and id; clear nibble counter and carry to 0; go to CALC.
- Operand changes after acceptance SHALL be ignored.
REQ-017 Arbitration SHALL be round-robin.
- If only one valid is high, that requester wins.
- If both are high, the requester not served last wins.
- Last-served pointer SHALL update only on acceptance.
REQ-018 CALC: each cycle add nibble k of A and B plus the stored carry.
- Write the 4-bit result into nibble k of the sum register; store carry-out; increment k.
REQ-019 After nibble NIBBLES-1: sum[W] SHALL be set to the final carry-out, and the FSM goes to RESP.
- CALC SHALL last exactly NIBBLES cycles.
REQ-020 rsp_valid SHALL rise exactly NIBBLES+1 cycles after the acceptance edge (5 at default).
REQ-021 RESP: rsp_valid high; rsp_sum and rsp_id SHALL be held stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-022 No new request SHALL be accepted while in CALC or RESP.
- Minimum spacing between acceptances is NIBBLES+2 cycles.
REQ-023 Wrap-around: sums SHALL be exact modulo 2^(W+1); there is no overflow flag.
- Example: 0xFFFF+0xFFFF = 0x1FFFE.
REQ-024 A valid that drops before acceptance SHALL cancel that request silently; no response is produced.

Reset
REQ-025 While rst is high at a clock edge, the next state SHALL be:
- FSM IDLE, busy 0, rsp_valid 0, rsp_sum 0, rsp_id 0.
- Nibble counter 0, carry 0.
- Last-served pointer 1, so requester 0 wins the first contested grant.
REQ-026 During rst, req0_ready and req1_ready SHALL be 0.
REQ-027 Reset mid-CALC or mid-RESP SHALL abandon the operation; no response for it is ever emitted.

Verification
REQ-028 Reset: rst=1 for 2 cycles, then 0 -> busy=0, rsp_valid=0, rsp_sum=0, both ready=0 until a valid arrives.
REQ-029 Single request: req0 a=0x0002 b=0x0007, rsp_ready=1 -> req0_ready high 1 cycle; rsp_valid 5 cycles later with rsp_sum=0x00009, rsp_id=0.
REQ-030 Carry chain: a=0xFFFF b=0x0001 -> rsp_sum=0x10000; a=0xFFFF b=0xFFFF -> rsp_sum=0x1FFFE; a=0x000D b=0x000A -> 0x00017.
REQ-031 Contention: both valids held high for 4 operations -> grants 0,1,0,1 with correct sums per id; acceptances 6 cycles apart.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles in RESP -> rsp_valid stays high; rsp_sum/rsp_id stable; both ready=0; completes on the cycle rsp_ready=1.
REQ-033 Reset mid-op: rst pulsed in 2nd CALC cycle -> no rsp_valid for that op; next request a=0x0005 b=0x0003 returns 0x00008 with correct id.
